up_down_counter_db: RTL

//   Parametrised successor to the single-button up counter.

---
 rtl/up_down_counter_db.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/up_down_counter_db.sv
`default_nettype none
// ============================================================================
// Module      : up_down_counter_db
// Description : Up/down counter driven by two raw push-buttons. Each button
//               is synchronised (2 flops), debounced (DB_CYCLES stable
//               cycles) and edge-detected into a one-cycle step pulse. The
//               counter supports a synchronous parallel load, saturate or
//               wrap behaviour at the limits, and terminal-count flags.
// Ports       :
//   clk       in   1      system clock, all logic on posedge
//   rst       in   1      synchronous active-high reset
//   up        in   1      raw asynchronous up button, active-high
//   down      in   1      raw asynchronous down button, active-high
//   load      in   1      synchronous load strobe (already clean)
//   load_val  in   WIDTH  value to load (clamped to MAX_VAL)
//   count     out  WIDTH  current count (registered)
//   at_max    out  1      count == MAX_VAL (registered)
//   at_min    out  1      count == 0 (registered)
//   ovf       out  1      one-cycle pulse: up step taken at MAX_VAL
//   unf       out  1      one-cycle pulse: down step taken at 0
// Revision    : 1.0 - initial release
// ============================================================================
module up_down_counter_db #(
    parameter int WIDTH     = 3,
    parameter int MAX_VAL   = 2**WIDTH-1,
    parameter int DB_CYCLES = 4,
    parameter int WRAP      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
);

    // Debounce counter runs 0..DB_CYCLES-1; the level toggles on the
    // DB_CYCLES-th consecutive differing sample.
    localparam int               c_DBW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_DBW-1:0] c_DB_LAST = c_DBW'(DB_CYCLES - 1);
    localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MAX_VAL);

    // Channel 0 = up, channel 1 = down
    logic [1:0] w_raw;
    logic [1:0] w_step;

    assign w_raw = {down, up};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_chan
            logic             r_sync1;
            logic             r_sync2;
            logic             r_db;
            logic             r_db_d;
            logic             r_step;
            logic [c_DBW-1:0] r_dbcnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_db    <= 1'b0;
                    r_db_d  <= 1'b0;
                    r_step  <= 1'b0;
                    r_dbcnt <= '0;
                end else begin
                    r_sync1 <= w_raw[g];
                    r_sync2 <= r_sync1;

                    // Any sample agreeing with the accepted level restarts
                    // the stability count, so short glitches never toggle.
                    if (r_sync2 == r_db) begin
                        r_dbcnt <= '0;
                    end else if (r_dbcnt == c_DB_LAST) begin
                        r_db    <= ~r_db;
                        r_dbcnt <= '0;
                    end else begin
                        r_dbcnt <= r_dbcnt + 1'b1;
                    end

                    // Press (rising edge of debounced level) only; releases
                    // and long holds generate nothing.
                    r_db_d <= r_db;
                    r_step <= r_db & ~r_db_d;
                end
            end

            assign w_step[g] = r_step;
        end
    endgenerate

    logic w_up_step;
    logic w_dn_step;

    assign w_up_step = w_step[0];
    assign w_dn_step = w_step[1];

    logic [WIDTH-1:0] r_count;
    logic             r_at_max;
    logic             r_at_min;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_next;
    logic             w_ovf;
    logic             w_unf;

    always_comb begin
        w_next = r_count;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        if (load) begin
            // Load overrides any step arriving in the same cycle.
            w_next = (load_val > c_MAX) ? c_MAX : load_val;
        end else if (w_up_step && w_dn_step) begin
            // Opposing steps cancel.
            w_next = r_count;
        end else if (w_up_step) begin
            if (r_count == c_MAX) begin
                w_ovf = 1'b1;
                if (WRAP != 0) begin
                    w_next = '0;
                end
            end else begin
                w_next = r_count + 1'b1;
            end
        end else if (w_dn_step) begin
            if (r_count == '0) begin
                w_unf = 1'b1;
                if (WRAP != 0) begin
                    w_next = c_MAX;
                end
            end else begin
                w_next = r_count - 1'b1;
            end
        end
    end

    // Flags are computed from the next count so they always line up with
    // the registered count value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_at_max <= 1'b0;
            r_at_min <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_count  <= w_next;
            r_at_max <= (w_next == c_MAX);
            r_at_min <= (w_next == '0);
            r_ovf    <= w_ovf;
            r_unf    <= w_unf;
        end
    end

    assign count  = r_count;
    assign at_max = r_at_max;
    assign at_min = r_at_min;
    assign ovf    = r_ovf;
    assign unf    = r_unf;

endmodule
`default_nettype wire
